tlights_monitor: RTL and testbench

- Receiving end of the `rag` traffic-light bus: samples the 3-bit red/amber/green output of the light controller every clock.
- Decodes each sample into a phase, checks the UK sequence R -> R+A -> G -> A -> R, and counts completed cycles.
- Flags illegal patterns, out-of-order phases and, optionally, over-long phases.
- Sits beside the controller in system benches and on-chip as a safety checker.

---
 rtl/tlights_pkg.sv | 16 +
 rtl/tlights_decode.sv | 11 +
 rtl/tlights_monitor.sv | 96 +++++++++
 tb/tb_tlights_monitor.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/tlights_pkg.sv
// tlights_pkg: shared phase/error types and rag bus patterns for the traffic-light controller, monitor and benches
package tlights_pkg;
  typedef enum logic [1:0] {PH_R, PH_RA, PH_G, PH_A} tl_phase_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_ILLEGAL, ERR_ORDER, ERR_DWELL} tl_err_t;
  typedef enum logic {ST_SYNC, ST_LOCK} tl_state_t;
  localparam logic [2:0] RAG_R  = 3'b100;
  localparam logic [2:0] RAG_RA = 3'b110;
  localparam logic [2:0] RAG_G  = 3'b001;
  localparam logic [2:0] RAG_A  = 3'b010;
  function automatic tl_phase_t next_phase(input tl_phase_t p);
    logic [1:0] v;
    v = p;
    v = v + 2'd1;
    return tl_phase_t'(v);
  endfunction
endpackage

// File: rtl/tlights_decode.sv
// tlights_decode: combinational rag pattern -> {legal, phase}
module tlights_decode
  import tlights_pkg::*;
(
  input  logic [2:0] i_rag,
  output logic       o_legal,
  output tl_phase_t  o_phase
);
  assign o_legal = (i_rag == RAG_R) || (i_rag == RAG_RA) || (i_rag == RAG_G) || (i_rag == RAG_A);
  assign o_phase = (i_rag == RAG_RA) ? PH_RA : (i_rag == RAG_G) ? PH_G : (i_rag == RAG_A) ? PH_A : PH_R;
endmodule

// File: rtl/tlights_monitor.sv
// tlights_monitor: checks the UK R->RA->G->A->R light sequence, counts cycles, flags errors.
// Define TLIGHTS_MONITOR_DWELL_CHECK_EN to also flag phases held longer than MAX_DWELL samples.
module tlights_monitor
  import tlights_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MAX_DWELL = 16,
  parameter int DWELL_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       rag,
  output logic [1:0]       phase,
  output logic             in_sync,
  output logic             err,
  output logic             err_sticky,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] seq_count
);
  tl_state_t          r_state;
  tl_phase_t          r_phase;
  tl_err_t            r_err_code;
  logic               r_in_sync;
  logic               r_err;
  logic               r_err_sticky;
  logic [CNT_W-1:0]   r_seq_count;
  logic [DWELL_W-1:0] r_dwell;
  logic               w_legal;
  tl_phase_t          w_phase;
  logic               w_same;
  logic               w_next;
  logic               w_dwell_over;
  tl_err_t            w_code;

  tlights_decode u_decode (
    .i_rag   (rag),
    .o_legal (w_legal),
    .o_phase (w_phase)
  );

  assign w_same = w_phase == r_phase;
  assign w_next = w_phase == next_phase(r_phase);
`ifdef TLIGHTS_MONITOR_DWELL_CHECK_EN
  assign w_dwell_over = w_same && (r_dwell == DWELL_W'(MAX_DWELL));
`else
  assign w_dwell_over = 1'b0;
`endif
  // illegal beats every in-lock check; in SYNC only illegal patterns are errors
  assign w_code = !w_legal ? ERR_ILLEGAL :
                  (r_state == ST_SYNC) ? ERR_NONE :
                  w_dwell_over ? ERR_DWELL :
                  (w_same || w_next) ? ERR_NONE : ERR_ORDER;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_SYNC;
      r_phase      <= PH_R;
      r_in_sync    <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_seq_count  <= '0;
      r_dwell      <= '0;
    end else begin
      r_err <= 1'b0;
      if (w_code != ERR_NONE) begin
        r_err        <= 1'b1;
        r_err_sticky <= 1'b1;
        r_err_code   <= w_code;
        r_state      <= ST_SYNC;
        r_in_sync    <= 1'b0;
      end else if (r_state == ST_SYNC) begin
        if (w_phase == PH_R) begin
          r_state   <= ST_LOCK;
          r_phase   <= PH_R;
          r_in_sync <= 1'b1;
          r_dwell   <= DWELL_W'(1);
        end
      end else if (w_same) begin
        r_dwell <= (&r_dwell) ? r_dwell : r_dwell + 1'b1;
      end else begin
        r_phase <= w_phase;
        r_dwell <= DWELL_W'(1);
        if (r_phase == PH_A && !(&r_seq_count))
          r_seq_count <= r_seq_count + 1'b1;
      end
    end
  end

  assign phase      = r_phase;
  assign in_sync    = r_in_sync;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;
  assign err_code   = r_err_code;
  assign seq_count  = r_seq_count;
endmodule

// File: tb/tb_tlights_monitor.sv
// tb_tlights_monitor: directed vector table, cycle-saturation run and random stimulus against a reference model
module tb_tlights_monitor;
  localparam int MAXD = 4;
  localparam int DWW  = 5;
`ifdef TLIGHTS_MONITOR_DWELL_CHECK_EN
  localparam bit DW = 1'b1;
`else
  localparam bit DW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rag = 3'b100;
  logic [1:0] phase;
  logic       in_sync, err, err_sticky;
  logic [1:0] err_code;
  logic [7:0] seq_count;

  tlights_monitor #(.CNT_W(8), .MAX_DWELL(MAXD), .DWELL_W(DWW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rag        (rag),
    .phase      (phase),
    .in_sync    (in_sync),
    .err        (err),
    .err_sticky (err_sticky),
    .err_code   (err_code),
    .seq_count  (seq_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  bit m_lock, m_err, m_st;
  int m_ph, m_dw, m_cnt, m_code;

  typedef struct {
    logic [2:0] r;
    logic       rn;
    int         ph, sy, er, st, cd, cnt;
  } vec_t;
  vec_t vecs[$];

  logic [2:0] pat [4] = '{3'b100, 3'b110, 3'b001, 3'b010};

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int dec(input logic [2:0] r);
    for (int i = 0; i < 4; i++) if (pat[i] == r) return i;
    return -1;
  endfunction

  task automatic m_fault(input int code);
    m_err = 1'b1;
    m_st = 1'b1;
    m_code = code;
    m_lock = 1'b0;
  endtask

  task automatic model(input logic [2:0] r, input logic rn);
    int p;
    if (!rn) begin
      m_lock = 0; m_err = 0; m_st = 0; m_ph = 0; m_dw = 0; m_cnt = 0; m_code = 0;
      return;
    end
    p = dec(r);
    m_err = 1'b0;
    if (p < 0) m_fault(1);
    else if (!m_lock) begin
      if (p == 0) begin m_lock = 1; m_ph = 0; m_dw = 1; end
    end else if (p == m_ph) begin
      if (DW && m_dw + 1 > MAXD) m_fault(3);
      else if (m_dw < (1 << DWW) - 1) m_dw++;
    end else if (p == (m_ph + 1) % 4) begin
      if (m_ph == 3 && m_cnt < 255) m_cnt++;
      m_ph = p;
      m_dw = 1;
    end else m_fault(2);
  endtask

  task automatic step(input logic [2:0] r, input logic rn);
    @(negedge clk);
    rag = r;
    rst_n = rn;
    @(posedge clk);
    model(r, rn);
    #1;
    chk("m_phase", int'(phase), m_ph);
    chk("m_in_sync", int'(in_sync), int'(m_lock));
    chk("m_err", int'(err), int'(m_err));
    chk("m_err_sticky", int'(err_sticky), int'(m_st));
    chk("m_err_code", int'(err_code), m_code);
    chk("m_seq_count", int'(seq_count), m_cnt);
  endtask

  task automatic add(input logic [2:0] r, input logic rn, input int ph, sy, er, st, cd, cnt);
    vec_t v;
    v.r = r; v.rn = rn; v.ph = ph; v.sy = sy; v.er = er; v.st = st; v.cd = cd; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    logic [2:0] r;
    add(3'b100, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) add(3'b100, 1, 0, 1, 0, 0, 0, 0);
    add(3'b110, 1, 1, 1, 0, 0, 0, 0);
    repeat (3) add(3'b001, 1, 2, 1, 0, 0, 0, 0);
    add(3'b010, 1, 3, 1, 0, 0, 0, 0);
    add(3'b100, 1, 0, 1, 0, 0, 0, 1);
    add(3'b110, 1, 1, 1, 0, 0, 0, 1);
    add(3'b001, 1, 2, 1, 0, 0, 0, 1);
    add(3'b111, 1, 2, 0, 1, 1, 1, 1);
    add(3'b100, 1, 0, 1, 0, 1, 1, 1);
    add(3'b001, 1, 0, 0, 1, 1, 2, 1);
    add(3'b001, 1, 0, 0, 0, 1, 2, 1);
    add(3'b010, 1, 0, 0, 0, 1, 2, 1);
    add(3'b100, 1, 0, 1, 0, 1, 2, 1);
    add(3'b110, 1, 1, 1, 0, 1, 2, 1);
    add(3'b001, 1, 2, 1, 0, 1, 2, 1);
    add(3'b010, 1, 3, 1, 0, 1, 2, 1);
    add(3'b010, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) add(3'b100, 1, 0, 1, 0, 0, 0, 0);
    add(3'b100, 1, 0, DW ? 0 : 1, DW ? 1 : 0, DW ? 1 : 0, DW ? 3 : 0, 0);
    add(3'b100, 0, 0, 0, 0, 0, 0, 0);
    add(3'b000, 1, 0, 0, 1, 1, 1, 0);
    add(3'b100, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].rn);
      chk("t_phase", int'(phase), vecs[i].ph);
      chk("t_in_sync", int'(in_sync), vecs[i].sy);
      chk("t_err", int'(err), vecs[i].er);
      chk("t_err_sticky", int'(err_sticky), vecs[i].st);
      chk("t_err_code", int'(err_code), vecs[i].cd);
      chk("t_seq_count", int'(seq_count), vecs[i].cnt);
    end

    step(3'b100, 1);
    for (int i = 0; i < 260; i++) begin
      step(3'b110, 1);
      step(3'b001, 1);
      step(3'b010, 1);
      step(3'b100, 1);
      if (i == 253) chk("sat_254", int'(seq_count), 254);
    end
    chk("sat_255", int'(seq_count), 255);
    chk("sat_no_err", int'(err_sticky), 0);

    step(3'b100, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) step(pat[$urandom_range(0, 3)], 0);
      else begin
        if ($urandom_range(0, 9) < 7)
          r = !m_lock ? pat[$urandom_range(0, 3) == 0 ? 1 : 0] :
              ($urandom_range(0, 1) == 1) ? pat[m_ph] : pat[(m_ph + 1) % 4];
        else r = 3'($urandom_range(0, 7));
        step(r, 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
